// File: rtl/keys_event_ctrl.sv
// Key PIO event controller: acknowledges key interrupts, captures edges, queues key masks.
// Optional per-key lockout is enabled with KEYS_EVENT_CTRL_LOCKOUT_EN.
module keys_event_ctrl #(
    parameter logic [3:0] MASK_INIT      = 4'hF,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         LOCKOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        keys_irq,
    output logic        evt_valid,
    output logic [3:0]  evt_data,
    input  logic        evt_ready,
    output logic        overflow,
    input  logic        ovf_clr
);
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C   = FIFO_DEPTH[AW:0];
    localparam logic [19:0]    LOCK_LOAD = LOCKOUT_CYCLES[19:0];

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CAP, S_CLR, S_PUSH} state_t;

    state_t       r_state, w_state_nxt;
    logic         w_cs, w_wn;
    logic [1:0]   w_addr;
    logic [31:0]  w_wd;
    logic [3:0]   r_pending;
    logic [3:0]   w_locked;
    logic [3:0]   w_entry;
    logic [3:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]  r_count;
    logic         w_push_req, w_push, w_pop, w_drop;
    logic [27:0]  w_unused_rd;

    assign w_unused_rd = avm_readdata[31:4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_INIT;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cs        = 1'b0;
        w_wn        = 1'b1;
        w_addr      = 2'd0;
        w_wd        = 32'h0;
        case (r_state)
            S_INIT: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = 2'd2; w_wd = {28'b0, MASK_INIT};
                w_state_nxt = S_IDLE;
            end
            S_IDLE: if (keys_irq) w_state_nxt = S_RD;
            S_RD: begin
                w_cs = 1'b1; w_addr = 2'd3;
                w_state_nxt = S_CAP;
            end
            S_CAP:  w_state_nxt = S_CLR;
            S_CLR: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = 2'd3; w_wd = 32'hF;
                w_state_nxt = S_PUSH;
            end
            S_PUSH:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // The FSM sits in INIT while reset is held, so the bus decode is forced idle by reset_n itself.
    assign avm_chipselect = reset_n & w_cs;
    assign avm_write_n    = ~reset_n | w_wn;
    assign avm_address    = reset_n ? w_addr : 2'd0;
    assign avm_writedata  = reset_n ? w_wd : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               r_pending <= 4'b0;
        else if (r_state == S_CAP)  r_pending <= avm_readdata[3:0];
    end

`ifdef KEYS_EVENT_CTRL_LOCKOUT_EN
    logic [19:0] r_lock_cnt [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_lock_cnt[i] <= 20'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Dropped entries still reload, so a bouncing key cannot refill a full FIFO.
                if (r_state == S_PUSH && w_entry[i]) r_lock_cnt[i] <= LOCK_LOAD;
                else if (r_lock_cnt[i] != 20'd0)     r_lock_cnt[i] <= r_lock_cnt[i] - 20'd1;
            end
        end
    end

    always_comb begin
        w_locked = 4'b0;
        for (int i = 0; i < 4; i++) w_locked[i] = (r_lock_cnt[i] != 20'd0);
    end
`else
    logic [19:0] w_unused_lock;
    assign w_unused_lock = LOCK_LOAD;
    assign w_locked      = 4'b0;
`endif

    assign w_entry    = r_pending & ~w_locked;
    assign evt_valid  = (r_count != '0);
    assign evt_data   = evt_valid ? r_mem[r_rd_ptr] : 4'b0;
    assign w_pop      = evt_valid & evt_ready;
    assign w_push_req = (r_state == S_PUSH) && (w_entry != 4'b0);
    assign w_push     = w_push_req && ((r_count < DEPTH_C) || w_pop);
    assign w_drop     = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     overflow <= 1'b0;
        else if (ovf_clr) overflow <= 1'b0;
        else if (w_drop)  overflow <= 1'b1;
    end
endmodule

// File: tb/tb_keys_event_ctrl.sv
// Self-checking bench for keys_event_ctrl: directed and random key events against a queue-based model.
module tb_keys_event_ctrl;
    localparam int DEPTH = 4;
    localparam int LOCK  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        keys_irq;
    logic        evt_valid;
    logic [3:0]  evt_data;
    logic        evt_ready;
    logic        overflow;
    logic        ovf_clr;
    logic [3:0]  pio_edges;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [3:0] exp_q [$];
    logic       exp_ovf;
    int         lock_t [4];
    bit         lock_v [4];

    keys_event_ctrl #(.MASK_INIT(4'hF), .FIFO_DEPTH(DEPTH), .LOCKOUT_CYCLES(LOCK)) dut (
        .clk(clk), .reset_n(reset_n),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .keys_irq(keys_irq),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Key PIO edge-capture register: registered read, valid the cycle after the address.
    always @(posedge clk)
        avm_readdata <= (avm_chipselect && avm_write_n && avm_address == 2'd3) ? {28'b0, pio_edges} : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_vld"}, evt_valid, exp_q.size() > 0);
        check({tag, "_dat"}, evt_data, (exp_q.size() > 0) ? exp_q[0] : 4'h0);
        check({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    function automatic logic [3:0] model_locked(input int t);
        logic [3:0] l;
        l = 4'b0;
`ifdef KEYS_EVENT_CTRL_LOCKOUT_EN
        for (int i = 0; i < 4; i++) l[i] = lock_v[i] && ((t - lock_t[i]) <= LOCK);
`endif
        return l;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin lock_v[i] = 1'b0; lock_t[i] = 0; end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"}, avm_chipselect, 1'b0);
        check({tag, "_wn"}, avm_write_n, 1'b1);
        check({tag, "_addr"}, avm_address, 2'd0);
        check({tag, "_wd"}, avm_writedata, 32'h0);
        check({tag, "_vld"}, evt_valid, 1'b0);
        check({tag, "_dat"}, evt_data, 4'h0);
        check({tag, "_ovf"}, overflow, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("init_cs", avm_chipselect, 1'b1);
        check("init_wn", avm_write_n, 1'b0);
        check("init_addr", avm_address, 2'd2);
        check("init_wd", avm_writedata, 32'hF);
        tick();
        check("post_init_cs", avm_chipselect, 1'b0);
        check("post_init_wn", avm_write_n, 1'b1);
        check_stream("post_init");
    endtask

    task automatic idle(input logic rdy, input logic clr);
        check("idle_cs", avm_chipselect, 1'b0);
        check_stream("idle");
        evt_ready = rdy;
        ovf_clr   = clr;
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (clr) exp_ovf = 1'b0;
        tick();
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic fire(input logic [3:0] mask, input logic pop, input logic clr);
        logic [3:0] ent;
        bit         drop;
        drop = 1'b0;
        check_stream("pre");
        pio_edges = mask;
        keys_irq  = 1'b1;
        tick();
        keys_irq  = 1'b0;
        check("rd_cs", avm_chipselect, 1'b1);
        check("rd_wn", avm_write_n, 1'b1);
        check("rd_addr", avm_address, 2'd3);
        tick();
        check("cap_cs", avm_chipselect, 1'b0);
        tick();
        check("clr_cs", avm_chipselect, 1'b1);
        check("clr_wn", avm_write_n, 1'b0);
        check("clr_addr", avm_address, 2'd3);
        check("clr_wd", avm_writedata, 32'hF);
        tick();
        check("push_cs", avm_chipselect, 1'b0);
        check_stream("push");
        evt_ready = pop;
        ovf_clr   = clr;
        ent = mask & ~model_locked(cyc);
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (ent != 4'b0) begin
            for (int i = 0; i < 4; i++)
                if (ent[i]) begin lock_v[i] = 1'b1; lock_t[i] = cyc; end
            if (exp_q.size() < DEPTH) exp_q.push_back(ent);
            else drop = 1'b1;
        end
        exp_ovf = clr ? 1'b0 : (exp_ovf | drop);
        tick();
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        check_stream("post");
    endtask

    task automatic drain();
        while (exp_q.size() > 0) idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int g = 0; g < n; g++) idle(1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] base;
        reset_n   = 1'b0;
        keys_irq  = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        pio_edges = 4'b0;
        model_reset();
        #1;
        check_reset_outputs("rst");
        tick(); tick();
        release_reset();

        // Single key event: 5-cycle irq-to-valid latency.
        fire(4'b0100, 1'b0, 1'b0);
        drain();
        gap(12);

        // Five distinct events with no consumer: fifth dropped, then cleared.
        base = 4'($urandom_range(0, 14));
        for (int k = 0; k < 5; k++) begin
            fire(4'(((base + 4'(2 * k)) % 15) + 1), 1'b0, 1'b0);
            gap(8);
        end
        check("ovf_set", overflow, 1'b1);
        idle(1'b0, 1'b1);
        check("ovf_clr", overflow, 1'b0);
        drain();
        gap(12);

        // Full FIFO with a pop in the push cycle: push accepted, no overflow.
        for (int k = 0; k < 4; k++) begin fire(4'($urandom_range(1, 15)), 1'b0, 1'b0); gap(8); end
        fire(4'($urandom_range(1, 15)), 1'b1, 1'b0);
        check("full_pushpop_ovf", overflow, 1'b0);
        drain();
        gap(12);

        // Drop coinciding with ovf_clr: clear wins; a later drop sets it.
        for (int k = 0; k < 4; k++) begin fire(4'($urandom_range(1, 15)), 1'b0, 1'b0); gap(8); end
        fire(4'($urandom_range(1, 15)), 1'b0, 1'b1);
        gap(8);
        fire(4'($urandom_range(1, 15)), 1'b0, 1'b0);
        drain();
        gap(12);

        // Key 0 events 5 cycles apart, then 12 cycles after the first.
        fire(4'b0001, 1'b0, 1'b0);
        fire(4'b0001, 1'b0, 1'b0);
        gap(2);
        fire(4'b0001, 1'b0, 1'b0);
`ifdef KEYS_EVENT_CTRL_LOCKOUT_EN
        check("lock_count", exp_q.size(), 2);
`else
        check("lock_count", exp_q.size(), 3);
`endif
        drain();

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            fire(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            for (int g = 0; g < int'($urandom_range(0, 6)); g++)
                idle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        drain();

        // Reset asserted while the FSM is in CAP, with queued events and overflow set.
        for (int k = 0; k < 5; k++) begin fire(4'($urandom_range(1, 15)), 1'b0, 1'b0); gap(11); end
        pio_edges = 4'b0010;
        keys_irq  = 1'b1;
        tick();
        keys_irq  = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        tick();
        release_reset();
        fire(4'b1000, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
